// File: rtl/pool2d_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pool2d_stream                                                              |
// | Streaming POOLxPOOL max/average pooling, raster input, direct RAM writes. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pool2d_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_W       = 10,
  parameter int IN_H       = 10,
  parameter int POOL       = 2,
  parameter int CHANNELS   = 1,
  parameter int ADDR_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [ADDR_W-1:0]     i_base_addr,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_out_wea,
  output logic [ADDR_W-1:0]     o_out_addr,
  output logic [DATA_WIDTH-1:0] o_out_din,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int OUT_W = IN_W / POOL;
  localparam int OUT_H = IN_H / POOL;
  localparam int S     = $clog2(POOL * POOL);
  localparam int ACC_W = DATA_WIDTH + S;
  localparam int PL    = $clog2(POOL);
  localparam int XW    = $clog2(IN_W);
  localparam int YW    = $clog2(IN_H);
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int OXW   = XW - PL;
  localparam int OYW   = YW - PL;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   r_state;
  logic [XW-1:0]            r_x;
  logic [YW-1:0]            r_y;
  logic [CW-1:0]            r_ch;
  logic                     r_mode;
  logic [ADDR_W-1:0]        r_base;
  logic signed [ACC_W-1:0]  r_line [OUT_W];

  logic                     w_accept;
  logic [OXW-1:0]           w_ox;
  logic [OYW-1:0]           w_oy;
  logic                     w_first;
  logic                     w_last;
  logic                     w_x_end;
  logic                     w_y_end;
  logic                     w_ch_end;
  logic signed [ACC_W-1:0]  w_px;
  logic signed [ACC_W-1:0]  w_entry;
  logic signed [ACC_W-1:0]  w_comb;
  logic [DATA_WIDTH-1:0]    w_din;
  logic [ADDR_W-1:0]        w_addr;

  assign w_accept = (r_state == S_RUN) && i_in_valid;
  assign w_ox     = r_x[XW-1:PL];
  assign w_oy     = r_y[YW-1:PL];
  assign w_first  = (r_x[PL-1:0] == '0) && (r_y[PL-1:0] == '0);
  assign w_last   = (&r_x[PL-1:0]) && (&r_y[PL-1:0]);
  assign w_x_end  = (r_x == XW'(IN_W - 1));
  assign w_y_end  = (r_y == YW'(IN_H - 1));
  assign w_ch_end = (r_ch == CW'(CHANNELS - 1));
  assign w_px     = {{S{i_in_data[DATA_WIDTH-1]}}, i_in_data};
  assign w_entry  = r_line[w_ox];

  always_comb begin
    w_comb = w_px;
    if (!w_first) begin
      if (r_mode) begin
        w_comb = w_entry + w_px;
      end else if (w_px > w_entry) begin
        w_comb = w_px;
      end else begin
        w_comb = w_entry;
      end
    end
  end

  // Arithmetic shift gives the floor of the window mean, including negative sums.
  assign w_din  = r_mode ? DATA_WIDTH'(w_comb >>> S) : DATA_WIDTH'(w_comb);
  assign w_addr = r_base
                + ADDR_W'(r_ch) * ADDR_W'(OUT_W * OUT_H)
                + ADDR_W'(w_oy) * ADDR_W'(OUT_W)
                + ADDR_W'(w_ox);

  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_line[w_ox] <= w_comb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_ch       <= '0;
      r_mode     <= 1'b0;
      r_base     <= '0;
      o_in_ready <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_out_wea  <= 1'b0;
      o_out_addr <= '0;
      o_out_din  <= '0;
    end else begin
      o_out_wea <= 1'b0;
      o_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_RUN;
            r_x        <= '0;
            r_y        <= '0;
            r_ch       <= '0;
            r_mode     <= i_mode;
            r_base     <= i_base_addr;
            o_in_ready <= 1'b1;
            o_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_last) begin
              o_out_wea  <= 1'b1;
              o_out_addr <= w_addr;
              o_out_din  <= w_din;
            end
            if (w_x_end) begin
              r_x <= '0;
              if (w_y_end) begin
                r_y  <= '0;
                r_ch <= w_ch_end ? '0 : r_ch + 1'b1;
                if (w_ch_end) begin
                  r_state    <= S_DRAIN;
                  o_in_ready <= 1'b0;
                end
              end else begin
                r_y <= r_y + 1'b1;
              end
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
